// File: rtl/axi_txn_gate.sv
// rtl/axi_txn_gate.sv - outstanding AXI write/read limiter with drain/quiesce sequence
// Optional macro AXI_TXN_GATE_STATS_EN adds the stall_cycles output.
module axi_txn_gate #(
  parameter int MAX_WR_TXNS = 4,
  parameter int MAX_RD_TXNS = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 aclk,
  input  logic                 rstn,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic                 m_axi_bvalid,
  input  logic                 m_axi_bready,
  input  logic                 m_axi_rvalid,
  input  logic                 m_axi_rready,
  input  logic                 m_axi_rlast,
  input  logic                 drain_req,
  output logic                 idle,
  output logic [CNT_WIDTH-1:0] wr_cnt,
  output logic [CNT_WIDTH-1:0] rd_cnt,
  output logic                 cnt_err
`ifdef AXI_TXN_GATE_STATS_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_IDLE} state_t;

  localparam logic [CNT_WIDTH-1:0] WR_MAX  = CNT_WIDTH'(MAX_WR_TXNS);
  localparam logic [CNT_WIDTH-1:0] RD_MAX  = CNT_WIDTH'(MAX_RD_TXNS);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_idle;
  logic                 w_idle_nxt;
  logic                 r_aw_hold;
  logic                 r_ar_hold;
  logic [CNT_WIDTH-1:0] r_wr_cnt;
  logic [CNT_WIDTH-1:0] r_rd_cnt;
  logic                 r_cnt_err;
  logic                 w_aw_allow;
  logic                 w_ar_allow;
  logic                 w_aw_hs;
  logic                 w_ar_hs;
  logic                 w_b_hs;
  logic                 w_r_hs;

  // A held valid always completes, so the hold bypasses both the limit and the drain block.
  assign w_aw_allow = r_aw_hold | ((r_state == ST_RUN) && (r_wr_cnt < WR_MAX));
  assign w_ar_allow = r_ar_hold | ((r_state == ST_RUN) && (r_rd_cnt < RD_MAX));

  assign m_axi_awvalid = s_axi_awvalid & w_aw_allow;
  assign s_axi_awready = m_axi_awready & w_aw_allow;
  assign m_axi_arvalid = s_axi_arvalid & w_ar_allow;
  assign s_axi_arready = m_axi_arready & w_ar_allow;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;
  assign w_b_hs  = m_axi_bvalid & m_axi_bready;
  assign w_r_hs  = m_axi_rvalid & m_axi_rready & m_axi_rlast;

  assign idle    = r_idle;
  assign wr_cnt  = r_wr_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign cnt_err = r_cnt_err;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_RUN;
      r_idle  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (drain_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          w_state_nxt = ST_RUN;
        end else if ((r_wr_cnt == '0) && (r_rd_cnt == '0) && !r_aw_hold && !r_ar_hold) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!drain_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_idle_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_aw_hold <= 1'b0;
      r_ar_hold <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_hold <= 1'b0;
      else if (m_axi_awvalid) r_aw_hold <= 1'b1;
      if (w_ar_hs) r_ar_hold <= 1'b0;
      else if (m_axi_arvalid) r_ar_hold <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_cnt_err <= 1'b0;
    end else begin
      if (w_aw_hs && !w_b_hs) r_wr_cnt <= r_wr_cnt + CNT_ONE;
      else if (!w_aw_hs && w_b_hs && (r_wr_cnt != '0)) r_wr_cnt <= r_wr_cnt - CNT_ONE;
      if (w_ar_hs && !w_r_hs) r_rd_cnt <= r_rd_cnt + CNT_ONE;
      else if (!w_ar_hs && w_r_hs && (r_rd_cnt != '0)) r_rd_cnt <= r_rd_cnt - CNT_ONE;
      // A response with nothing outstanding means the downstream lost sync with us.
      if ((w_b_hs && (r_wr_cnt == '0)) || (w_r_hs && (r_rd_cnt == '0))) r_cnt_err <= 1'b1;
    end
  end

`ifdef AXI_TXN_GATE_STATS_EN
  logic [31:0] r_stall_cycles;
  logic        w_stall;

  assign w_stall      = (s_axi_awvalid & ~w_aw_allow) | (s_axi_arvalid & ~w_ar_allow);
  assign stall_cycles = r_stall_cycles;

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles <= '0;
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_DRAIN)) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
